// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared ysyx_22050039 configuration: fetch FSM state encoding and the default reset PC.
package ysyx_22050039_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_WAIT,
    IFU_VALID
  } ifu_state_e;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22050039_ifu_reg.sv
// Generic write-enabled register with asynchronous active-low reset to a fixed value.
module ysyx_22050039_Reg #(
  parameter int unsigned             WIDTH     = 1,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one-outstanding fetch FSM with redirect/drop handling.
// Optional misaligned-PC trap reporting under YSYX_22050039_IFU_MISALIGN_CHK_EN.
module ysyx_22050039_ifu #(
  parameter int unsigned         XLEN     = 64,
  parameter int unsigned         INST_LEN = 32,
  parameter logic [XLEN-1:0]     RESET_PC = XLEN'(ysyx_22050039_ifu_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_valid,
  output logic [XLEN-1:0]     mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [INST_LEN-1:0] mem_resp_data,
  output logic                inst_valid,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  input  logic                inst_ready,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [63:0]         fetch_cnt
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
  ,
  output logic                misalign
`endif
);

  import ysyx_22050039_ifu_pkg::*;

  ifu_state_e          state, state_nxt;
  logic                drop, drop_nxt;
  logic [INST_LEN-1:0] inst_nxt;
  logic [63:0]         cnt_nxt;
  logic                pc_wen;
  logic [XLEN-1:0]     pc_din;
  logic                misaligned;

`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
  assign misaligned = |pc[1:0];
  assign misalign   = (state == IFU_VALID) && misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req_addr = pc;

  ysyx_22050039_Reg #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (pc_wen),
    .din  (pc_din),
    .dout (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IFU_IDLE;
      drop      <= 1'b0;
      inst      <= '0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drop      <= drop_nxt;
      inst      <= inst_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drop_nxt      = drop;
    inst_nxt      = inst;
    cnt_nxt       = fetch_cnt;
    pc_wen        = 1'b0;
    pc_din        = pc + XLEN'(4);
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;

    // A redirect always wins the PC write, whatever the state does.
    if (redirect_valid) begin
      pc_wen = 1'b1;
      pc_din = redirect_pc;
    end

    case (state)
      IFU_IDLE: state_nxt = IFU_REQ;

      IFU_REQ: begin
        if (misaligned) begin
          if (!redirect_valid) begin
            state_nxt = IFU_VALID;
            inst_nxt  = '0;
          end
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_nxt = IFU_WAIT;
            drop_nxt  = redirect_valid;
          end
        end
      end

      IFU_WAIT: begin
        // A redirect coinciding with the response makes that response stale too.
        if (mem_resp_valid) begin
          if (drop || redirect_valid) begin
            state_nxt = IFU_REQ;
            drop_nxt  = 1'b0;
          end else begin
            inst_nxt  = mem_resp_data;
            state_nxt = IFU_VALID;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end

      IFU_VALID: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          state_nxt = IFU_REQ;
        end else if (inst_ready) begin
          pc_wen    = 1'b1;
          cnt_nxt   = fetch_cnt + 64'd1;
          state_nxt = IFU_REQ;
        end
      end

      default: state_nxt = IFU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Self-checking bench for ysyx_22050039_ifu: architectural PC/count model plus directed scenarios.
module tb_ysyx_22050039_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int resp_delay = 1;

  ysyx_22050039_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc             (pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0413;
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] a);
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    if (a[1:0] != 2'b00) return 32'h0;
`endif
    return mem_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: responds resp_delay cycles into WAIT with the word at the accepted address.
  initial begin
    logic        hs, pend;
    logic [63:0] hs_addr, p_addr;
    int          cnt;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    pend = 1'b0;
    p_addr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      hs      = rst && mem_req_valid && mem_req_ready;
      hs_addr = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (hs) begin
        pend   = 1'b1;
        cnt    = resp_delay;
        p_addr = hs_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(p_addr);
          pend = 1'b0;
        end
      end
    end
  end

  // Architectural model: PC follows redirects and accepted instructions; count follows accepted ones.
  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  logic        outstanding;
  logic        hold;
  logic [31:0] h_inst;
  logic [63:0] h_pc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc        <= 64'h8000_0000;
      m_cnt       <= '0;
      outstanding <= 1'b0;
      hold        <= 1'b0;
      h_inst      <= '0;
      h_pc        <= '0;
    end else begin
      if (redirect_valid) m_pc <= redirect_pc;
      else if (inst_valid && inst_ready) m_pc <= m_pc + 64'd4;
      if (!redirect_valid && inst_valid && inst_ready) m_cnt <= m_cnt + 64'd1;
      if (mem_req_valid && mem_req_ready) outstanding <= 1'b1;
      else if (mem_resp_valid) outstanding <= 1'b0;
      hold   <= inst_valid && !inst_ready && !redirect_valid;
      h_inst <= inst;
      h_pc   <= pc;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_valid) begin
        check("req_addr", mem_req_addr, m_pc);
        check("one_in_flight", {63'd0, outstanding}, 64'd0);
      end
      if (inst_valid) begin
        check("pc", pc, m_pc);
        check("inst", {32'd0, inst}, {32'd0, exp_inst(m_pc)});
        check("req_while_valid", {63'd0, mem_req_valid}, 64'd0);
      end
      check("fetch_cnt", fetch_cnt, m_cnt);
      if (hold) begin
        check("hold_valid", {63'd0, inst_valid}, 64'd1);
        check("hold_inst", {32'd0, inst}, {32'd0, h_inst});
        check("hold_pc", pc, h_pc);
      end
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
      check("misalign", {63'd0, misalign}, {63'd0, inst_valid && (m_pc[1:0] != 2'b00)});
      if (m_pc[1:0] != 2'b00) check("misaligned_req", {63'd0, mem_req_valid}, 64'd0);
`endif
    end
  end

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) return;
      step();
    end
    check({name, "_timeout"}, {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) return;
      step();
    end
    check({name, "_timeout"}, {63'd0, mem_req_valid}, 64'd1);
  endtask

  initial begin
    rst            = 1'b0;
    mem_req_ready  = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_pc", pc, 64'h8000_0000);
    check("rst_inst", {32'd0, inst}, 64'd0);
    check("rst_cnt", fetch_cnt, 64'd0);

    // First fetch after reset release.
    rst = 1'b1;
    step();
    check("first_req_valid", {63'd0, mem_req_valid}, 64'd1);
    check("first_req_addr", mem_req_addr, 64'h8000_0000);
    step();
    check("first_wait_no_valid", {63'd0, inst_valid}, 64'd0);
    step();
    check("cycle3_valid", {63'd0, inst_valid}, 64'd1);
    check("cycle3_inst", {32'd0, inst}, 64'h0000_0413);

    // Decoder stall for 5 cycles.
    for (int i = 0; i < 5; i++) step();
    check("stall_inst", {32'd0, inst}, 64'h0000_0413);
    check("stall_pc", pc, 64'h8000_0000);
    check("stall_no_req", {63'd0, mem_req_valid}, 64'd0);
    check("stall_cnt", fetch_cnt, 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("hs_cnt", fetch_cnt, 64'd1);
    check("hs_next_addr", mem_req_addr, 64'h8000_0004);

    // Redirect while waiting on memory: stale word must be dropped.
    resp_delay = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    resp_delay = 1;
    wait_req("wait_redir");
    check("wait_redir_addr", mem_req_addr, 64'h8000_0100);
    check("wait_redir_cnt", fetch_cnt, 64'd1);
    wait_valid("wait_redir_valid");
    check("wait_redir_inst", {32'd0, inst}, 64'h9357_9ADF);

    // Accept and redirect in the same VALID cycle.
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0040;
    step();
    inst_ready     = 1'b0;
    check("valid_redir_addr", mem_req_addr, 64'h8000_0040);
    check("valid_redir_cnt", fetch_cnt, 64'd1);

    // Redirect in REQ without handshake.
    mem_req_ready = 1'b0;
    redirect_pc   = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("req_redir_valid", {63'd0, mem_req_valid}, 64'd1);
    check("req_redir_addr", mem_req_addr, 64'h8000_0200);

    // Redirect in REQ with handshake: the in-flight word is dropped.
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    step();
    redirect_valid = 1'b0;
    wait_req("req_hs_redir");
    check("req_hs_redir_addr", mem_req_addr, 64'h8000_0300);
    wait_valid("req_hs_redir_valid");
    check("req_hs_redir_inst", {32'd0, inst}, 64'h9357_98DF);
    check("req_hs_redir_cnt", fetch_cnt, 64'd1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("wrap_addr", mem_req_addr, 64'h0);
    check("wrap_cnt", fetch_cnt, 64'd2);

    // Reset mid-transaction; the late response lands while the FSM is idle.
    resp_delay = 2;
    step();
    rst = 1'b0;
    #1;
    check("async_rst_req", {63'd0, mem_req_valid}, 64'd0);
    check("async_rst_pc", pc, 64'h8000_0000);
    check("async_rst_cnt", fetch_cnt, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    resp_delay = 1;
    step();
    check("post_rst_addr", mem_req_addr, 64'h8000_0000);
    wait_valid("post_rst_valid");
    check("post_rst_inst", {32'd0, inst}, 64'h0000_0413);
    check("post_rst_cnt", fetch_cnt, 64'd0);

`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0002;
    step();
    redirect_valid = 1'b0;
    check("mis_no_req", {63'd0, mem_req_valid}, 64'd0);
    step();
    check("mis_valid", {63'd0, inst_valid}, 64'd1);
    check("mis_flag", {63'd0, misalign}, 64'd1);
    check("mis_inst", {32'd0, inst}, 64'd0);
`endif

    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_ifu.md
YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_IFU

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the PC and address width.
REQ-002 Parameter INST_LEN, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 64'h8000_0000, SHALL set the PC value loaded at reset.
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Ports mem_req_valid (output, 1) and mem_req_addr (output, XLEN) SHALL form the fetch request to instruction memory.
REQ-007 Port mem_req_ready, input, 1: memory accepts the request.
REQ-008 Ports mem_resp_valid (input, 1) and mem_resp_data (input, INST_LEN) SHALL carry the fetched word.
REQ-009 Ports inst_valid (output, 1), inst (output, INST_LEN) and pc (output, XLEN) SHALL present the instruction to the decoder.
REQ-010 Port inst_ready, input, 1: decoder consumes the instruction.
REQ-011 Ports redirect_valid (input, 1) and redirect_pc (input, XLEN) SHALL carry a control-flow redirect from execute.
REQ-012 Port fetch_cnt, output, 64: count of instructions delivered.

Function
REQ-013 FSM states IDLE, REQ, WAIT and VALID SHALL apply; IDLE exits to REQ on the first clock after reset release.
REQ-014 In REQ, mem_req_valid=1 and mem_req_addr=pc; on mem_req_ready=1 the FSM SHALL go to WAIT.
REQ-015 In WAIT, on mem_resp_valid=1 the word SHALL be latched into inst and the FSM SHALL go to VALID.
REQ-016 In VALID, inst_valid=1 and inst/pc SHALL stay stable until inst_ready=1; the handshake SHALL set pc<=pc+4, increment fetch_cnt, and go to REQ.
REQ-017 Latency: with mem_req_ready=1 and the response one cycle later, inst_valid SHALL assert 2 cycles after REQ entry.
REQ-018 pc+4 SHALL wrap modulo 2^XLEN.
REQ-019 redirect_valid in any state SHALL load pc<=redirect_pc and take priority over pc+4.
REQ-020 A redirect in VALID SHALL drop the held instruction without counting it, even if inst_ready=1 in the same cycle, and go to REQ.
REQ-021 A redirect in WAIT, or in REQ with the handshake completing the same cycle, SHALL set a drop flag; the next response SHALL be discarded and the FSM SHALL go to REQ.
REQ-022 A redirect in REQ without a handshake SHALL keep REQ with the new address on the next cycle.
REQ-023 mem_req_valid SHALL never be asserted while a response is outstanding (at most one in flight).

Reset
REQ-024 On rst=0: state=IDLE, pc=RESET_PC, inst=0, drop flag=0, fetch_cnt=0, and mem_req_valid and inst_valid both 0, immediately and asynchronously.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; a response arriving while in IDLE SHALL be ignored.

Configuration
REQ-026 Macro YSYX_22050039_IFU_MISALIGN_CHK_EN defined: output misalign (1) SHALL assert in VALID when pc[1:0]!=0, and no request SHALL be issued for a misaligned pc; the FSM SHALL go directly to VALID with inst=0.
REQ-027 Macro undefined: misalign port SHALL be absent and pc[1:0] SHALL be ignored (the address is passed through unchanged).

Structure
REQ-028 The FSM state enum and the RESET_PC constant SHALL reside in the shared ysyx_22050039 config package.
REQ-029 The PC register SHALL be an instance of the existing ysyx_22050039_Reg sub-module; there SHALL be no other sub-modules.

Verification
REQ-030 Reset release with mem_req_ready=1 and a one-cycle response of 32'h00000413 -> mem_req_addr=0x80000000; inst_valid with inst=0x00000413 at cycle 3.
REQ-031 inst_ready held at 0 for 5 cycles -> inst and pc stable; no new request; fetch_cnt unchanged.
REQ-032 Redirect to 0x80000100 in WAIT -> stale response dropped; next request at 0x80000100; fetch_cnt unchanged.
REQ-033 inst_ready=1 and redirect to 0x80000040 in the same VALID cycle -> next address 0x80000040, not pc+4; fetch_cnt unchanged.
REQ-034 pc=0xFFFFFFFF_FFFFFFFC handshake -> next address 0x0.
REQ-035 Macro defined, redirect to 0x80000002 -> no memory request; misalign=1 with inst_valid=1.
